// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM test sequencer: state encoding,
// default LFSR polynomial/seed and the per-bank key rotation helper.
package jtsdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PWAIT = 2'd1,
    ST_RWAIT = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [15:0] DEF_TAPS = 16'hD295;
  localparam logic [15:0] DEF_SEED = 16'hAAAA;

  // Low kw bits of an lw-bit value rotated right by (bank*kw) mod lw.
  function automatic logic [31:0] key_rot(input logic [63:0] lfsr,
                                          input int unsigned lw,
                                          input int unsigned kw,
                                          input int unsigned bank);
    logic [31:0] key;
    int unsigned rot;
    key = '0;
    rot = (bank * kw) % lw;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < kw) key[5'(i)] = lfsr[6'((i + rot) % lw)];
    end
    return key;
  endfunction

endpackage

// File: rtl/jtsdram_lfsr.sv
// Fibonacci-style LFSR shifting right with feedback into the MSB;
// load returns it to SEED and takes priority over step.
module jtsdram_lfsr
  import jtsdram_pkg::*;
#(
  parameter int unsigned     LW   = 16,
  parameter logic [LW-1:0]   TAPS = LW'(DEF_TAPS),
  parameter logic [LW-1:0]   SEED = LW'(DEF_SEED)
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          i_step,
  input  logic          i_load,
  output logic [LW-1:0] o_q
);

  logic [LW-1:0] r_q;
  logic          w_fb;

  assign w_fb = ^(r_q & TAPS);
  assign o_q  = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_q <= SEED;
    else if (i_load) r_q <= SEED;
    else if (i_step) r_q <= {w_fb, r_q[LW-1:1]};
  end

endmodule

// File: rtl/jtsdram_seqn.sv
// Program/read test sequencer across BANKS bank checkers with LFSR keys.
// Optional watchdog built when JTSDRAM_SEQ_TIMEOUT_EN is defined.
module jtsdram_seqn
  import jtsdram_pkg::*;
#(
  parameter int unsigned   BANKS = 4,
  parameter int unsigned   KW    = 5,
  parameter int unsigned   LW    = 16,
  parameter logic [LW-1:0] TAPS  = LW'(DEF_TAPS),
  parameter logic [LW-1:0] SEED  = LW'(DEF_SEED),
  parameter int unsigned   ITW   = 16,
  parameter int unsigned   TOW   = 20
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                run,
  input  logic                clr,
  input  logic                halt_on_err,
  output logic [BANKS*KW-1:0] keys,
  output logic                prog_start,
  input  logic                prog_done,
  output logic                rd_start,
  input  logic [BANKS-1:0]    ba_done,
  input  logic [BANKS-1:0]    ba_err,
  output logic                busy,
  output logic                halted,
  output logic [ITW-1:0]      iter,
  output logic [ITW-1:0]      err_cnt,
  output logic [BANKS-1:0]    err_bank,
  output logic                timeout
);

  localparam int unsigned PW = $clog2(BANKS + 1);
  localparam int unsigned SW = ITW + PW;

  state_t           r_state, w_state_nx;
  logic             r_prog_start, w_prog_start_nx;
  logic             r_rd_start, w_rd_start_nx;
  logic [BANKS-1:0] r_done_mask, w_done_mask_nx;
  logic             r_iter_err, w_iter_err_nx;
  logic [ITW-1:0]   r_iter, w_iter_nx;
  logic [ITW-1:0]   r_err_cnt, w_err_cnt_nx;
  logic [BANKS-1:0] r_err_bank, w_err_bank_nx;
  logic [BANKS-1:0] w_new_err;
  logic [PW-1:0]    w_pop;
  logic [SW-1:0]    w_err_sum;
  logic             w_step, w_load, w_wd_expire;
  logic [LW-1:0]    w_lfsr;

  jtsdram_lfsr #(.LW(LW), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .rst    (rst),
    .clk    (clk),
    .i_step (w_step),
    .i_load (w_load),
    .o_q    (w_lfsr)
  );

  for (genvar b = 0; b < BANKS; b++) begin : g_key
    assign keys[b*KW +: KW] = KW'(key_rot(64'(w_lfsr), LW, KW, b));
  end

  assign prog_start = r_prog_start;
  assign rd_start   = r_rd_start;
  assign busy       = (r_state == ST_PWAIT) || (r_state == ST_RWAIT);
  assign halted     = (r_state == ST_HALT);
  assign iter       = r_iter;
  assign err_cnt    = r_err_cnt;
  assign err_bank   = r_err_bank;

  // Banks whose done bit rises in the mask this cycle while reporting an error.
  assign w_new_err = ba_done & ~r_done_mask & ba_err;

  always_comb begin
    w_pop = '0;
    for (int b = 0; b < BANKS; b++) w_pop = w_pop + PW'(w_new_err[b]);
    w_err_sum = SW'(r_err_cnt) + SW'(w_pop);
  end

`ifdef JTSDRAM_SEQ_TIMEOUT_EN
  logic [TOW-1:0] r_wd;
  logic           r_timeout;

  // Expire one count early so HALT and timeout land as the counter tops out.
  assign w_wd_expire = (r_wd == ~TOW'(1));
  assign timeout     = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (clr) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_state_nx != r_state) r_wd <= '0;
      else if (busy)             r_wd <= r_wd + TOW'(1);
      if (busy && w_wd_expire)   r_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_tow;
  assign w_unused_tow = ^TOW'(0);
  assign w_wd_expire  = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    w_state_nx      = r_state;
    w_prog_start_nx = 1'b0;
    w_rd_start_nx   = 1'b0;
    w_done_mask_nx  = r_done_mask;
    w_iter_err_nx   = r_iter_err;
    w_iter_nx       = r_iter;
    w_err_cnt_nx    = r_err_cnt;
    w_err_bank_nx   = r_err_bank;
    w_step          = 1'b0;
    w_load          = 1'b0;
    if (clr) begin
      w_state_nx     = ST_IDLE;
      w_done_mask_nx = '0;
      w_iter_err_nx  = 1'b0;
      w_iter_nx      = '0;
      w_err_cnt_nx   = '0;
      w_err_bank_nx  = '0;
      w_load         = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            w_prog_start_nx = 1'b1;
            w_state_nx      = ST_PWAIT;
          end
        end
        ST_PWAIT: begin
          if (w_wd_expire) begin
            w_state_nx = ST_HALT;
          end else if (prog_done && !r_prog_start) begin
            w_rd_start_nx  = 1'b1;
            w_done_mask_nx = '0;
            w_iter_err_nx  = 1'b0;
            w_state_nx     = ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (w_wd_expire) begin
            w_state_nx = ST_HALT;
          end else begin
            w_done_mask_nx = r_done_mask | ba_done;
            w_err_bank_nx  = r_err_bank | w_new_err;
            w_iter_err_nx  = r_iter_err | (|w_new_err);
            w_err_cnt_nx   = (w_err_sum > SW'({ITW{1'b1}})) ? {ITW{1'b1}}
                                                            : ITW'(w_err_sum);
            if (&(r_done_mask | ba_done)) begin
              if (w_iter_err_nx && halt_on_err) begin
                w_state_nx = ST_HALT;
              end else begin
                w_step     = 1'b1;
                w_iter_nx  = (&r_iter) ? r_iter : r_iter + ITW'(1);
                w_state_nx = ST_IDLE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_prog_start <= 1'b0;
      r_rd_start   <= 1'b0;
      r_done_mask  <= '0;
      r_iter_err   <= 1'b0;
      r_iter       <= '0;
      r_err_cnt    <= '0;
      r_err_bank   <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_prog_start <= w_prog_start_nx;
      r_rd_start   <= w_rd_start_nx;
      r_done_mask  <= w_done_mask_nx;
      r_iter_err   <= w_iter_err_nx;
      r_iter       <= w_iter_nx;
      r_err_cnt    <= w_err_cnt_nx;
      r_err_bank   <= w_err_bank_nx;
    end
  end

endmodule

// File: tb/tb_jtsdram_seqn.sv
// Directed bench for jtsdram_seqn with a transaction-level model checked every cycle.
// Watchdog case adapts to whether JTSDRAM_SEQ_TIMEOUT_EN is defined.
module tb_jtsdram_seqn;

  localparam int BANKS = 4;
  localparam int KW    = 5;
  localparam int LW    = 16;
  localparam int ITW   = 2;
  localparam int TOW   = 4;
  localparam int IMAX  = (1 << ITW) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                run = 1'b0;
  logic                clr = 1'b0;
  logic                halt_on_err = 1'b0;
  logic                prog_done = 1'b0;
  logic [BANKS-1:0]    ba_done = '0;
  logic [BANKS-1:0]    ba_err = '0;
  logic [BANKS*KW-1:0] keys;
  logic                prog_start, rd_start, busy, halted, timeout;
  logic [ITW-1:0]      iter, err_cnt;
  logic [BANKS-1:0]    err_bank;

  jtsdram_seqn #(
    .BANKS(BANKS), .KW(KW), .LW(LW), .TAPS(16'hD295), .SEED(16'hAAAA),
    .ITW(ITW), .TOW(TOW)
  ) dut (
    .rst(rst), .clk(clk), .run(run), .clr(clr), .halt_on_err(halt_on_err),
    .keys(keys), .prog_start(prog_start), .prog_done(prog_done),
    .rd_start(rd_start), .ba_done(ba_done), .ba_err(ba_err), .busy(busy),
    .halted(halted), .iter(iter), .err_cnt(err_cnt), .err_bank(err_bank),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Expected architectural state
  logic [15:0] m_lfsr;
  int          m_iter, m_err_cnt;
  logic [3:0]  m_err_bank;
  bit          m_busy, m_halted, m_timeout, m_ps, m_rs;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int fb;
    fb = $countones(l & 16'hD295) % 2;
    return (l >> 1) | (16'(fb) << 15);
  endfunction

  function automatic logic [19:0] model_keys(input logic [15:0] l);
    logic [31:0] d;
    logic [19:0] k;
    d = {l, l};
    for (int b = 0; b < 4; b++) k[b*5 +: 5] = 5'(d >> ((b * 5) % 16));
    return k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("keys",       32'(keys),       32'(model_keys(m_lfsr)));
      check("iter",       32'(iter),       32'(m_iter));
      check("err_cnt",    32'(err_cnt),    32'(m_err_cnt));
      check("err_bank",   32'(err_bank),   32'(m_err_bank));
      check("busy",       32'(busy),       32'(m_busy));
      check("halted",     32'(halted),     32'(m_halted));
      check("timeout",    32'(timeout),    32'(m_timeout));
      check("prog_start", 32'(prog_start), 32'(m_ps));
      check("rd_start",   32'(rd_start),   32'(m_rs));
    end
  end

  task automatic m_reset();
    m_lfsr = 16'hAAAA; m_iter = 0; m_err_cnt = 0; m_err_bank = '0;
    m_busy = 0; m_halted = 0; m_timeout = 0; m_ps = 0; m_rs = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One program/read iteration; dN = done offset of bank N from the rd_start cycle.
  task automatic iteration(input int pd, input bit stale, input int d0, input int d1,
                           input int d2, input int d3, input logic [3:0] errs,
                           input bit hon, input bit keep_run, input bit level);
    int dc[4];
    int last;
    bit anyerr;
    dc = '{d0, d1, d2, d3};
    last = 0;
    for (int b = 0; b < 4; b++) if (dc[b] > last) last = dc[b];
    anyerr = 0;
    halt_on_err = hon;
    run = 1'b1;
    tick();
    m_ps = 1; m_busy = 1;
    if (!keep_run) run = 1'b0;
    prog_done = stale;
    for (int k = 1; k <= pd; k++) begin
      tick();
      m_ps = 0;
      prog_done = (k == pd);
    end
    tick();
    prog_done = 1'b0;
    m_rs = 1;
    for (int t = 0; t <= last; t++) begin
      for (int b = 0; b < 4; b++) ba_done[b] = level ? (t >= dc[b]) : (t == dc[b]);
      ba_err = errs;
      tick();
      m_rs = 0;
      for (int b = 0; b < 4; b++) begin
        if (t == dc[b] && errs[b]) begin
          m_err_bank[b] = 1'b1;
          m_err_cnt = (m_err_cnt < IMAX) ? m_err_cnt + 1 : IMAX;
          anyerr = 1;
        end
      end
      if (t == last) begin
        m_busy = 0;
        if (anyerr && hon) m_halted = 1;
        else begin
          m_iter = (m_iter < IMAX) ? m_iter + 1 : IMAX;
          m_lfsr = lfsr_next(m_lfsr);
        end
      end
    end
    if (level) tick();
    ba_done = '0;
    ba_err = '0;
  endtask

  task automatic do_clr();
    run = 1'b1;
    clr = 1'b1;
    tick();
    m_reset();
    clr = 1'b0;
    run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_watchdog: still running at %0t", $time);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    m_reset();
    chk_en = 1'b1;
    #22 rst = 1'b0;
    check("rst_keys",   32'(keys), 32'h000AAAAA);
    check("rst_outs",   32'({prog_start, rd_start, busy, halted, timeout, iter, err_cnt, err_bank}), 32'h0);

    // All banks done together, no errors; run held for back-to-back start
    iteration(3, 0, 1, 1, 1, 1, 4'b0000, 0, 1, 0);
    check("A_model_lfsr", 32'(m_lfsr), 32'h0000D555);
    check("A_iter",       32'(iter),   32'd1);

    // Staggered dones with bank2 error; run dropped mid-iteration
    iteration(3, 0, 2, 5, 9, 11, 4'b0100, 0, 0, 0);
    check("B_err_cnt",  32'(err_cnt),  32'd1);
    check("B_err_bank", 32'(err_bank), 32'h4);
    check("B_iter",     32'(iter),     32'd2);
    repeat (3) tick();

    // Stale prog_done during prog_start, level dones, three errors -> counter saturates
    iteration(2, 1, 0, 3, 3, 1, 4'b1011, 0, 0, 1);
    check("C_err_cnt_sat", 32'(err_cnt),  32'd3);
    check("C_err_bank",    32'(err_bank), 32'hF);
    check("C_iter",        32'(iter),     32'd3);

    iteration(1, 0, 1, 1, 1, 1, 4'b0000, 0, 0, 0);
    check("D_iter_sat", 32'(iter), 32'd3);
    do_clr();
    check("clr1_iter", 32'(iter),    32'd0);
    check("clr1_err",  32'(err_cnt), 32'd0);
    check("clr1_keys", 32'(keys),    32'h000AAAAA);

    // Halt on error keeps the failing pattern and blocks new starts
    iteration(3, 0, 2, 5, 9, 11, 4'b0100, 1, 1, 0);
    repeat (5) tick();
    check("H_halted", 32'(halted),   32'd1);
    check("H_keys",   32'(keys),     32'h000AAAAA);
    check("H_bank",   32'(err_bank), 32'h4);
    do_clr();
    check("clr2_halted", 32'(halted),   32'd0);
    check("clr2_bank",   32'(err_bank), 32'h0);
    check("clr2_busy",   32'(busy),     32'd0);

    // prog_done never returns
    halt_on_err = 1'b0;
    run = 1'b1;
    tick();
    m_ps = 1; m_busy = 1;
    run = 1'b0;
`ifdef JTSDRAM_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      tick();
      m_ps = 0;
      if (k == 15) begin
        m_timeout = 1; m_halted = 1; m_busy = 0;
      end
    end
    check("T_timeout", 32'(timeout), 32'd1);
    check("T_halted",  32'(halted),  32'd1);
    check("T_keys",    32'(keys),    32'h000AAAAA);
`else
    for (int k = 1; k <= 30; k++) begin
      tick();
      m_ps = 0;
    end
    check("T_no_timeout", 32'(timeout), 32'd0);
    check("T_still_busy", 32'(busy),    32'd1);
`endif
    do_clr();
    check("clr3_timeout", 32'(timeout), 32'd0);

    // Asynchronous reset in RWAIT
    run = 1'b1;
    tick();
    m_ps = 1; m_busy = 1;
    run = 1'b0;
    tick();
    m_ps = 0;
    prog_done = 1'b1;
    tick();
    prog_done = 1'b0;
    m_rs = 1;
    ba_done = 4'b0011;
    ba_err = 4'b0001;
    tick();
    m_rs = 0;
    m_err_bank[0] = 1'b1;
    m_err_cnt = 1;
    #2;
    rst = 1'b1;
    m_reset();
    ba_done = '0;
    ba_err = '0;
    #1;
    check("R_keys", 32'(keys), 32'h000AAAAA);
    check("R_outs", 32'({prog_start, rd_start, busy, halted, timeout, iter, err_cnt, err_bank}), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Sequence restarts from SEED
    iteration(3, 0, 1, 1, 1, 1, 4'b0000, 0, 0, 0);
    check("G_model_lfsr", 32'(m_lfsr), 32'h0000D555);
    check("G_iter",       32'(iter),   32'd1);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
